fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, delayed-branch redirect and a one-word hold buffer.
// Define IMEM_WAIT_EN to honour imem_ready; otherwise every FETCH cycle completes a fetch.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_rst,
    input  logic        if_en,
    input  logic        id_rst,
    input  logic        id_en,
    input  logic [2:0]  pc_src,
    input  logic [31:0] fwd_rs_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        if_valid
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [2:0] SRC_JUMP   = 3'd1;
    localparam logic [2:0] SRC_BRANCH = 3'd2;
    localparam logic [2:0] SRC_FWD    = 3'd3;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;

    logic        ready_eff;
    logic        fetch_req;
    logic        fetch_done;
    logic        if_valid_w;
    logic [31:0] if_word;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        redirect_evt;
    logic [31:0] branch_off;
    logic [31:0] redirect_tgt;
    logic [31:0] next_pc;

`ifdef IMEM_WAIT_EN
    assign ready_eff = imem_ready;
`else
    logic unused_ready;
    assign unused_ready = imem_ready;
    assign ready_eff    = 1'b1;
`endif

    // if_rst withdraws the request in the same cycle so imem sees a cancel.
    assign fetch_req  = (state_q == ST_FETCH) && !if_rst;
    assign fetch_done = fetch_req && ready_eff;
    assign if_valid_w = fetch_done || (state_q == ST_HOLD);
    assign if_word    = (state_q == ST_HOLD) ? hold_q : imem_data;
    assign pc_plus4   = pc_q + 32'd4;

    assign retire       = if_valid_w && if_en && id_en && !id_rst;
    assign redirect_evt = id_valid_q && id_en && !id_rst &&
                          ((pc_src == SRC_JUMP) || (pc_src == SRC_BRANCH) || (pc_src == SRC_FWD));

    assign branch_off = {{14{id_inst_q[15]}}, id_inst_q[15:0], 2'b00};

    always_comb begin
        redirect_tgt = fwd_rs_data;
        case (pc_src)
            SRC_JUMP:   redirect_tgt = {id_pc4_q[31:28], id_inst_q[25:0], 2'b00};
            SRC_BRANCH: redirect_tgt = id_pc4_q + branch_off;
            default:    redirect_tgt = fwd_rs_data;
        endcase
        redirect_tgt[1:0] = 2'b00;
    end

    // A latched redirect belongs to the delay slot still to retire, so it wins.
    always_comb begin
        if (pend_q) begin
            next_pc = pend_tgt_q;
        end else if (redirect_evt) begin
            next_pc = redirect_tgt;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;

        if (if_rst) begin
            state_d    = ST_FETCH;
            pc_d       = 32'd0;
            hold_d     = 32'd0;
            pend_d     = 1'b0;
            pend_tgt_d = 32'd0;
            id_inst_d  = 32'd0;
            id_valid_d = 1'b0;
        end else if (retire) begin
            id_inst_d  = if_word;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
            pc_d       = next_pc;
            state_d    = ST_FETCH;
            pend_d     = 1'b0;
        end else begin
            if (fetch_done) begin
                hold_d  = imem_data;
                state_d = ST_HOLD;
            end
            if (id_en) begin
                id_inst_d  = 32'd0;
                id_valid_d = 1'b0;
            end
            if (redirect_evt) begin
                pend_d     = 1'b1;
                pend_tgt_d = redirect_tgt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= 32'd0;
            hold_q     <= 32'd0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'd0;
            id_inst_q  <= 32'd0;
            id_pc_q    <= 32'd0;
            id_pc4_q   <= 32'd0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_req    = fetch_req;
    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_w;
    assign id_inst     = id_inst_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc4_q;
    assign id_valid    = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, multi-cycle corner sequences, then random traffic vs a reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_rst, if_en, id_rst, id_en;
    logic [2:0]  pc_src;
    logic [31:0] fwd_rs_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] id_inst, id_pc, id_pc_plus4;
    logic        id_valid, if_valid;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
        .pc_src(pc_src), .fwd_rs_data(fwd_rs_data), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .id_inst(id_inst), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .if_valid(if_valid)
    );

    // Reference model: PC, optional held word, IF/ID contents and a pending redirect.
    logic [31:0] m_pc, m_hold_word, m_id_inst, m_id_pc, m_id_pc4, m_pend_tgt;
    logic        m_hold_full, m_id_valid, m_pend;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h20) return 32'h1000_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic eff_ready();
`ifdef IMEM_WAIT_EN
        return imem_ready;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_pc = 0; m_hold_word = 0; m_id_inst = 0; m_id_pc = 0; m_id_pc4 = 0;
        m_pend_tgt = 0; m_hold_full = 0; m_id_valid = 0; m_pend = 0;
    endtask

    task automatic step_model();
        logic        req, done, ifv, evt, ret;
        logic [31:0] word, tgt, off;
        req  = !m_hold_full && !if_rst;
        done = req && eff_ready();
        ifv  = done || m_hold_full;
        word = m_hold_full ? m_hold_word : imem_data;
        if (if_rst) begin
            m_pc = 0; m_hold_full = 0; m_hold_word = 0; m_pend = 0; m_id_valid = 0; m_id_inst = 0;
        end else begin
            evt = m_id_valid && id_en && !id_rst && (pc_src >= 3'd1) && (pc_src <= 3'd3);
            off = {{16{m_id_inst[15]}}, m_id_inst[15:0]};
            case (pc_src)
                3'd1:    tgt = {m_id_pc4[31:28], m_id_inst[25:0], 2'b00};
                3'd2:    tgt = m_id_pc4 + off * 32'd4;
                default: tgt = fwd_rs_data;
            endcase
            tgt = tgt & ~32'd3;
            ret = ifv && if_en && id_en && !id_rst;
            if (ret) begin
                m_id_inst = word; m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_id_valid = 1;
                m_pc = m_pend ? m_pend_tgt : (evt ? tgt : m_pc + 4);
                m_hold_full = 0; m_pend = 0;
            end else begin
                if (done) begin m_hold_word = word; m_hold_full = 1; end
                if (id_en) begin m_id_inst = 0; m_id_valid = 0; end
                if (evt) begin m_pend = 1; m_pend_tgt = tgt; end
            end
        end
    endtask

    task automatic drive(input logic irst, input logic ien, input logic dst, input logic den,
                         input logic [2:0] src, input logic rdy, input logic [31:0] fwd);
        if_rst = irst; if_en = ien; id_rst = dst; id_en = den;
        pc_src = src; imem_ready = rdy; fwd_rs_data = fwd;
        imem_data = rdy ? mem_word(m_pc) : $urandom();
    endtask

    task automatic check_model(input string tag);
        logic e_req, e_ifv;
        e_req = !m_hold_full && !if_rst;
        e_ifv = (e_req && eff_ready()) || m_hold_full;
        n_vec++;
        if (imem_req !== e_req || imem_addr !== m_pc || if_valid !== e_ifv || id_inst !== m_id_inst ||
            id_pc !== m_id_pc || id_pc_plus4 !== m_id_pc4 || id_valid !== m_id_valid) begin
            n_bad++;
            $display("FAIL %s: got req=%0b addr=%h ifv=%0b inst=%h pc=%h pc4=%h v=%0b want req=%0b addr=%h ifv=%0b inst=%h pc=%h pc4=%h v=%0b",
                     tag, imem_req, imem_addr, if_valid, id_inst, id_pc, id_pc_plus4, id_valid,
                     e_req, m_pc, e_ifv, m_id_inst, m_id_pc, m_id_pc4, m_id_valid);
        end
    endtask

    task automatic check_const(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic begin_cycle(input logic irst, input logic ien, input logic dst, input logic den,
                               input logic [2:0] src, input logic rdy, input logic [31:0] fwd,
                               input string tag);
        @(negedge clk);
        drive(irst, ien, dst, den, src, rdy, fwd);
        #1;
        check_model(tag);
    endtask

    task automatic end_cycle();
        @(posedge clk);
        step_model();
    endtask

    task automatic async_reset_cycle();
        @(negedge clk);
        #1 rst = 1'b1;
        model_reset();
        drive(0, 1, 0, 1, 3'd0, 1, 32'd0);
        #1;
        check_const("async_rst_addr", imem_addr, 32'd0);
        check_const("async_rst_valid", {31'd0, id_valid}, 32'd0);
        check_const("async_rst_idpc", id_pc, 32'd0);
        #1 rst = 1'b0;
        #1 check_model("after_async_rst");
        end_cycle();
    endtask

    typedef struct {
        logic [2:0]  src;
        logic [31:0] exp_addr;
        logic        exp_idv;
        logic [31:0] exp_idpc;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 10; k++)
            tbl[k] = '{3'd0, 32'(4 * k), (k >= 1), (k >= 1) ? 32'(4 * (k - 1)) : 32'd0};
        tbl[9].src = 3'd2;
        tbl[10]    = '{3'd0, 32'h34, 1'b1, 32'h24};
        tbl[11]    = '{3'd0, 32'h38, 1'b1, 32'h34};

        rst = 1'b1;
        model_reset();
        drive(0, 1, 0, 1, 3'd0, 1, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_const("reset_addr", imem_addr, 32'd0);
        check_const("reset_id_inst", id_inst, 32'd0);
        check_const("reset_id_pc", id_pc, 32'd0);
        check_const("reset_id_pc4", id_pc_plus4, 32'd0);
        check_const("reset_id_valid", {31'd0, id_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Straight-line fetch from 0, then a taken BEQ at 0x20 with offset 4.
        for (int k = 0; k < 12; k++) begin
            begin_cycle(0, 1, 0, 1, tbl[k].src, 1, 32'd0, $sformatf("tbl%0d", k));
            check_const($sformatf("tbl%0d_addr", k), imem_addr, tbl[k].exp_addr);
            check_const($sformatf("tbl%0d_req", k), {31'd0, imem_req}, 32'd1);
            check_const($sformatf("tbl%0d_idv", k), {31'd0, id_valid}, {31'd0, tbl[k].exp_idv});
            check_const($sformatf("tbl%0d_idpc", k), id_pc, tbl[k].exp_idpc);
            end_cycle();
        end

        // Both enables low while a fetch completes: the word parks in HOLD.
        begin_cycle(0, 0, 0, 0, 3'd0, 1, 32'd0, "stall_a");
        check_const("stall_a_addr", imem_addr, 32'h3C);
        end_cycle();
        begin_cycle(0, 0, 0, 0, 3'd0, 1, 32'd0, "stall_b");
        check_const("stall_b_req", {31'd0, imem_req}, 32'd0);
        check_const("stall_b_ifv", {31'd0, if_valid}, 32'd1);
        end_cycle();
        begin_cycle(0, 1, 0, 1, 3'd0, 1, 32'd0, "stall_release");
        check_const("release_req", {31'd0, imem_req}, 32'd0);
        end_cycle();

        // if_rst while the fetch at 0x40 is outstanding.
        begin_cycle(1, 1, 0, 1, 3'd0, 0, 32'd0, "ifrst");
        check_const("ifrst_addr", imem_addr, 32'h40);
        check_const("ifrst_req", {31'd0, imem_req}, 32'd0);
        check_const("held_retired_pc", id_pc, 32'h3C);
        check_const("held_retired_inst", id_inst, mem_word(32'h3C));
        end_cycle();
        begin_cycle(0, 1, 0, 1, 3'd0, 1, 32'd0, "after_ifrst");
        check_const("after_ifrst_addr", imem_addr, 32'd0);
        check_const("after_ifrst_idv", {31'd0, id_valid}, 32'd0);
        end_cycle();
        for (int k = 0; k < 3; k++) begin
            begin_cycle(0, 1, 0, 1, 3'd0, 1, 32'd0, $sformatf("refill%0d", k));
            end_cycle();
        end

        // Wait states at 0x10, then JR to 0x100 whose delay slot waits twice.
        begin_cycle(0, 1, 0, 1, 3'd0, 0, 32'd0, "wait_s0");
        check_const("wait_s0_addr", imem_addr, 32'h10);
        end_cycle();
        for (int k = 1; k <= 3; k++) begin
            begin_cycle(0, 1, 0, 1, 3'd0, (k == 3), 32'd0, $sformatf("wait_s%0d", k));
`ifdef IMEM_WAIT_EN
            check_const($sformatf("wait_s%0d_addr", k), imem_addr, 32'h10);
            check_const($sformatf("wait_s%0d_bubble", k), {31'd0, id_valid}, 32'd0);
`endif
            end_cycle();
        end
        begin_cycle(0, 1, 0, 1, 3'd3, 0, 32'h100, "jr_j0");
`ifdef IMEM_WAIT_EN
        check_const("jr_j0_idpc", id_pc, 32'h10);
        check_const("jr_j0_idv", {31'd0, id_valid}, 32'd1);
`endif
        end_cycle();
        begin_cycle(0, 1, 0, 1, 3'd0, 0, 32'h0, "jr_j1");
`ifdef IMEM_WAIT_EN
        check_const("jr_j1_addr", imem_addr, 32'h14);
`endif
        end_cycle();
        begin_cycle(0, 1, 0, 1, 3'd0, 1, 32'h0, "jr_j2");
        end_cycle();
        begin_cycle(0, 1, 0, 1, 3'd0, 1, 32'h0, "jr_j3");
`ifdef IMEM_WAIT_EN
        check_const("jr_target_addr", imem_addr, 32'h100);
        check_const("jr_delay_slot_pc", id_pc, 32'h14);
`endif
        end_cycle();

        async_reset_cycle();

        for (int n = 0; n < 3000; n++) begin
            logic [2:0] src;
            src = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            begin_cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0),
                        src, ($urandom_range(0, 2) != 0), $urandom(), $sformatf("rand%0d", n));
            end_cycle();
            if ($urandom_range(0, 499) == 0) async_reset_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
